reg_file_stack: RTL and testbench
=================================

// Module: reg_file_stack
// PURPOSE
//  Register file with an integrated hardware operand stack. Sits directly upstream
//  of the ALU and drives its readData1/readData2 operands.
//  - 32x32 general registers: 2 combinational read ports, 1 synchronous write port.
//  - DEPTH-entry LIFO that backs the push/pop used by negation/NOT ops.
//  - Pushed values come from read port 2; the top of stack is returned to writeback.
// PARAMETERS
//  DEPTH   8   stack entries; power of two, >= 2
// PORTS
//  clk         in   1    single clock, all state updates on posedge
//  reset       in   1    synchronous, active-high
//  readReg1    in   5    read port 1 address
//  readReg2    in   5    read port 2 address
//  writeReg    in   5    write address
//  writeData   in   32   write data
//  regWrite    in   1    write enable
//  push        in   1    push readData2 onto stack
//  pop         in   1    discard top of stack
//  errClear    in   1    clear stackErr
//  readData1   out  32   operand A to ALU
//  readData2   out  32   operand B to ALU
//  stackTop    out  32   current top entry, 0 when empty
//  stackCount  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
//  stackFull   out  1    stackCount==DEPTH
//  stackEmpty  out  1    stackCount==0
//  stackErr    out  1    sticky overflow/underflow flag
// BEHAVIOUR
//  Reset and priority
//  - Reset is synchronous, active-high, and has priority over every other input.
//  - On reset: all registers <= 0, sp <= 0, stackErr <= 0.
//    Resulting outputs: stackTop=0, stackCount=0, stackEmpty=1, stackFull=0.
//  - Reset asserted mid-sequence discards the stack contents and any same-cycle write.
//  Read ports (zero latency)
//  - Reads are combinational. Address 0 always reads 0.
//  - Write-through bypass: if regWrite && writeReg==readRegN && writeReg!=0,
//    then readDataN = writeData in the same cycle.
//  Write port
//  - On posedge with regWrite=1 and writeReg!=0: reg[writeReg] <= writeData.
//  - Writes to r0 are dropped.
//  Stack (sp = stackCount; entries stack[0..sp-1]; top = stack[sp-1])
//  - push only, not full:  stack[sp] <= readData2 (post-bypass value); sp <= sp+1.
//  - push only, full:      no change; stackErr <= 1.
//  - pop only, not empty:  sp <= sp-1. Entry contents are not cleared.
//  - pop only, empty:      no change; stackErr <= 1.
//  - push & pop, sp>0:     stack[sp-1] <= readData2; sp unchanged; no error (also when full).
//  - push & pop, sp==0:    treated as push only; sp becomes 1; no error.
//  Stack outputs and error flag
//  - stackTop, stackFull, stackEmpty are decoded from registered state only.
//  - Updates therefore become visible on the cycle after the edge.
//  - stackErr is sticky: set per the rules above, cleared by errClear.
//  - If set and clear coincide in the same cycle, the set wins.
//  - Stack ops are independent of regWrite. Both may happen in one cycle.
// TESTING
//  1. Reset -> all readData=0, stackEmpty=1, stackCount=0, stackErr=0.
//  2. regWrite r5=0x0000_00AA, readReg1=5 in the same cycle -> readData1=0xAA (bypass).
//     Next cycle, with regWrite=0 -> readData1=0xAA.
//  3. Write r0=0xFFFF_FFFF -> readData1 for readReg1=0 stays 0, before and after the edge.
//  4. r2=1..8, push 8 times (readReg2=2) -> stackFull=1, stackTop=8.
//     9th push -> stackErr=1, stackCount=8, stackTop=8.
//  5. From 3 entries {1,2,3}, push+pop with readData2=0x77 -> stackCount=3, stackTop=0x77.
//     Then pop x3 -> stackEmpty=1. Extra pop -> stackErr=1.
//  6. 2 entries pushed, then reset on the same cycle as push -> stackCount=0, stackTop=0,
//     stackErr=0, no entry written.

Source files
------------

// File: rtl/reg_file_stack.sv
// Register file with an integrated LIFO operand stack. Two combinational read
// ports with write-through bypass, one synchronous write port, and a
// DEPTH-entry stack fed from read port 2 whose state is exposed as registered flags.
module reg_file_stack #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [4:0]                 readReg1,
  input  logic [4:0]                 readReg2,
  input  logic [4:0]                 writeReg,
  input  logic [31:0]                writeData,
  input  logic                       regWrite,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       errClear,
  output logic [31:0]                readData1,
  output logic [31:0]                readData2,
  output logic [31:0]                stackTop,
  output logic [$clog2(DEPTH):0]     stackCount,
  output logic                       stackFull,
  output logic                       stackEmpty,
  output logic                       stackErr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   regs_q  [32];
  logic [31:0]   stack_q [DEPTH];
  logic [CW-1:0] sp_q, sp_d;
  logic          err_q, err_d;

  logic          full, empty;
  logic [CW-1:0] sp_m1;
  logic [PW-1:0] top_idx;
  logic          stk_we;
  logic [PW-1:0] stk_idx;
  logic          wr_en;

  assign wr_en   = regWrite && (writeReg != 5'd0);
  assign full    = (sp_q == CW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign sp_m1   = sp_q - CW'(1);
  assign top_idx = sp_m1[PW-1:0];

  // Read ports: r0 hard-wired to zero, same-cycle write forwarded to the reader
  always_comb begin
    if (readReg1 == 5'd0)                   readData1 = '0;
    else if (wr_en && writeReg == readReg1) readData1 = writeData;
    else                                    readData1 = regs_q[readReg1];
    if (readReg2 == 5'd0)                   readData2 = '0;
    else if (wr_en && writeReg == readReg2) readData2 = writeData;
    else                                    readData2 = regs_q[readReg2];
  end

  // Stack control: next pointer, entry write strobe/index and error set/clear
  always_comb begin
    sp_d    = sp_q;
    err_d   = err_q;
    stk_we  = 1'b0;
    stk_idx = sp_q[PW-1:0];
    if (errClear) err_d = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          stk_we  = 1'b1;
          stk_idx = sp_q[PW-1:0];
          sp_d    = sp_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty) err_d = 1'b1;
        else       sp_d  = sp_m1;
      end
      2'b11: begin
        // Replace the top in place; on an empty stack this degenerates to a push
        stk_we = 1'b1;
        if (empty) begin
          stk_idx = '0;
          sp_d    = CW'(1);
        end else begin
          stk_idx = top_idx;
        end
      end
      default: ;
    endcase
  end

  // Register file write port; reset clears every register and drops the write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[writeReg] <= writeData;
    end
  end

  // Stack storage, pointer and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (stk_we) stack_q[stk_idx] <= readData2;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  assign stackTop   = empty ? 32'd0 : stack_q[top_idx];
  assign stackCount = sp_q;
  assign stackFull  = full;
  assign stackEmpty = empty;
  assign stackErr   = err_q;

endmodule

// File: tb/tb_reg_file_stack.sv
// Directed bench for reg_file_stack: one vector per clock cycle. Inputs are
// driven after the falling edge and outputs sampled 1 ns later, so read ports
// show the current inputs and stack outputs show state from earlier edges.
module tb_reg_file_stack;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  readReg1, readReg2, writeReg;
  logic [31:0] writeData;
  logic        regWrite, push, pop, errClear;
  logic [31:0] readData1, readData2, stackTop;
  logic [3:0]  stackCount;
  logic        stackFull, stackEmpty, stackErr;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  reg_file_stack #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .readReg1(readReg1), .readReg2(readReg2),
    .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
    .push(push), .pop(pop), .errClear(errClear),
    .readData1(readData1), .readData2(readData2),
    .stackTop(stackTop), .stackCount(stackCount),
    .stackFull(stackFull), .stackEmpty(stackEmpty), .stackErr(stackErr)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  r1, r2, wr;
    logic [31:0] wd;
    logic        we, psh, pp, clr;
    logic [31:0] e1, e2, etop;
    logic [3:0]  ecnt;
    logic        efull, eempty, eerr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [4:0] r1, logic [4:0] r2,
                              logic [4:0] wr, logic [31:0] wd, logic we,
                              logic psh, logic pp, logic clr,
                              logic [31:0] e1, logic [31:0] e2, logic [31:0] etop,
                              logic [3:0] ecnt, logic eerr);
    vec_t v;
    v.rst = rst; v.r1 = r1; v.r2 = r2; v.wr = wr; v.wd = wd; v.we = we;
    v.psh = psh; v.pp = pp; v.clr = clr;
    v.e1 = e1; v.e2 = e2; v.etop = etop; v.ecnt = ecnt;
    v.efull = (ecnt == 4'd8); v.eempty = (ecnt == 4'd0); v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(vec_t v, int idx);
    @(negedge clk);
    reset = v.rst; readReg1 = v.r1; readReg2 = v.r2; writeReg = v.wr;
    writeData = v.wd; regWrite = v.we; push = v.psh; pop = v.pp; errClear = v.clr;
    #1;
    chk("readData1",  idx, readData1,         v.e1);
    chk("readData2",  idx, readData2,         v.e2);
    chk("stackTop",   idx, stackTop,          v.etop);
    chk("stackCount", idx, 32'(stackCount),   32'(v.ecnt));
    chk("stackFull",  idx, 32'(stackFull),    32'(v.efull));
    chk("stackEmpty", idx, 32'(stackEmpty),   32'(v.eempty));
    chk("stackErr",   idx, 32'(stackErr),     32'(v.eerr));
  endtask

  initial begin
    reset = 1'b1; readReg1 = '0; readReg2 = '0; writeReg = '0; writeData = '0;
    regWrite = 1'b0; push = 1'b0; pop = 1'b0; errClear = 1'b0;
    repeat (2) @(posedge clk);

    // Fields: rst r1 r2 wr wd we push pop clr | rd1 rd2 top cnt err (state before edge)
    // Reset state
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // Write r5 with same-cycle read (bypass), then plain read
    vecs.push_back(mk(0, 5, 0, 5, 32'hAA, 1, 0, 0, 0,  32'hAA, 0, 0, 0, 0));
    vecs.push_back(mk(0, 5, 0, 0, 0, 0, 0, 0, 0,  32'hAA, 0, 0, 0, 0));
    // r0 write dropped, before and after the edge
    vecs.push_back(mk(0, 0, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 5, 0, 0, 0, 0, 0, 0,  0, 32'hAA, 0, 0, 0));
    // r2 = k written and pushed through the bypass, k = 1..8
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 0, 2, 2, 32'(k), 1, 1, 0, 0,  0, 32'(k), 32'(k - 1), 4'(k - 1), 0));
    // 9th push on full stack
    vecs.push_back(mk(0, 0, 2, 0, 0, 0, 1, 0, 0,  0, 8, 8, 8, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 8, 8, 1));
    // Push+pop while full: top replaced, no error
    vecs.push_back(mk(0, 0, 4, 4, 32'h55, 1, 1, 1, 0,  0, 32'h55, 8, 8, 0));
    // Pop 8 -> 3
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 32'h55, 8, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 7, 7, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 6, 6, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 5, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 4, 4, 0));
    // From {1,2,3}: push+pop with readData2 = 0x77
    vecs.push_back(mk(0, 0, 3, 3, 32'h77, 1, 1, 1, 0,  0, 32'h77, 3, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 32'h77, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 2, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 1, 0));
    // Extra pop on empty -> error
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
    // Clear coinciding with another underflow: set wins
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // Push+pop on empty acts as push
    vecs.push_back(mk(0, 0, 5, 0, 0, 0, 1, 1, 0,  0, 32'hAA, 0, 0, 0));
    vecs.push_back(mk(0, 0, 3, 0, 0, 0, 1, 0, 0,  0, 32'h77, 32'hAA, 1, 0));
    // Reset on the same cycle as a push and a register write
    vecs.push_back(mk(1, 0, 5, 7, 32'h1234, 1, 1, 0, 0,  0, 32'hAA, 32'h77, 2, 0));
    vecs.push_back(mk(0, 7, 5, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset clears a set error flag
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0), 100);
    run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1), 101);
    run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0), 102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
